// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Takes a pc from the pc generator, issues one aligned doubleword read on a
// simple AR/R handshake bus, and returns the selected 32-bit instruction.
// Misaligned pcs and bus error responses both produce a nop with fetch_err.
module ifu_fetch #(
  parameter int DW = 64,  // data and address width in bits
  parameter int IW = 32   // instruction width in bits
) (
  input  logic          clk,
  input  logic          rstn,
  // pc generator side
  input  logic [DW-1:0] fetch_pc,
  input  logic          fetch_req,
  output logic [IW-1:0] inst,
  output logic          inst_valid,
  output logic          fetch_err,
  output logic          busy,
  // memory read address channel
  output logic [DW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  // memory read data channel
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp,
  input  logic          rvalid,
  output logic          rready
);

  // Canonical RISC-V nop (addi x0, x0, 0); returned on any faulted fetch.
  localparam logic [IW-1:0] NOP = IW'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   araddr_q, araddr_d;
  logic            wsel_q, wsel_d;        // 1: upper word of the doubleword
  logic [IW-1:0]   inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fetch_err_q, fetch_err_d;

  // A pc is fetchable only if it is word aligned.
  logic            pc_aligned;
  logic            resp_err;
  logic [IW-1:0]   rdata_word;

  assign pc_aligned = (fetch_pc[1:0] == 2'b00);
  assign resp_err   = (rresp != 2'b00);
  assign rdata_word = wsel_q ? rdata[2*IW-1:IW] : rdata[IW-1:0];

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      wsel_q       <= 1'b0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      wsel_q       <= wsel_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Next-state logic: requests are sampled only in IDLE, so a request seen
  // while a transaction is outstanding is dropped rather than queued.
  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    wsel_d       = wsel_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    fetch_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (pc_aligned) begin
            state_d  = ADDR;
            araddr_d = {fetch_pc[DW-1:3], 3'b000};
            wsel_d   = fetch_pc[2];
          end else begin
            // Misaligned: fault locally without touching the bus.
            inst_d       = NOP;
            inst_valid_d = 1'b1;
            fetch_err_d  = 1'b1;
          end
        end
      end

      ADDR: begin
        if (arready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (rvalid) begin
          state_d      = IDLE;
          inst_d       = resp_err ? NOP : rdata_word;
          inst_valid_d = 1'b1;
          fetch_err_d  = resp_err;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus handshakes are decoded from state so they can never overlap.
  assign arvalid    = (state_q == ADDR);
  assign rready     = (state_q == DATA);
  assign busy       = (state_q != IDLE);
  assign araddr     = araddr_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed plus randomized fetches against a transaction-level
// model of the fetch unit. Inputs driven and outputs sampled 1 time unit
// after each rising edge.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic [63:0] fetch_pc;
  logic        fetch_req;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic        busy;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int          n_vec;
  int          n_err;
  logic [31:0] last_inst;  // model: value inst must hold between pulses

  ifu_fetch #(.DW(64), .IW(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .fetch_pc  (fetch_pc),
    .fetch_req (fetch_req),
    .inst      (inst),
    .inst_valid(inst_valid),
    .fetch_err (fetch_err),
    .busy      (busy),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with bus noise; nothing may happen.
  task automatic idle_cycle();
    fetch_req = 1'b0;
    arready   = 1'($urandom_range(0, 1));
    rvalid    = 1'($urandom_range(0, 1));
    rdata     = {$urandom, $urandom};
    rresp     = 2'($urandom_range(0, 3));
    step();
    check("idle_valid", 64'(inst_valid), 64'(1'b0));
    check("idle_err", 64'(fetch_err), 64'(1'b0));
    check("idle_busy", 64'(busy), 64'(1'b0));
    check("idle_arvalid", 64'(arvalid), 64'(1'b0));
    check("idle_rready", 64'(rready), 64'(1'b0));
    check("idle_inst_hold", 64'(inst), 64'(last_inst));
    arready = 1'b0;
    rvalid  = 1'b0;
  endtask

  // One complete fetch. Called 1 unit after an edge; returns 1 unit after
  // the edge that completes it (valid pulse cycle), so a following call is
  // a back-to-back request.
  task automatic do_fetch(input logic [63:0] pc, input int ar_dly, input int r_dly,
                          input logic [63:0] data, input logic [1:0] resp);
    logic [63:0] exp_addr;
    logic [31:0] exp_inst;
    logic        exp_err;

    fetch_pc  = pc;
    fetch_req = 1'b1;
    arready   = 1'b0;
    rvalid    = 1'b0;
    step();
    fetch_req = 1'b0;
    fetch_pc  = {$urandom, $urandom};  // pc may change once accepted

    if (pc[1:0] != 2'b00) begin
      check("mis_valid", 64'(inst_valid), 64'(1'b1));
      check("mis_err", 64'(fetch_err), 64'(1'b1));
      check("mis_inst", 64'(inst), 64'(NOP));
      check("mis_arvalid", 64'(arvalid), 64'(1'b0));
      check("mis_busy", 64'(busy), 64'(1'b0));
      last_inst = NOP;
      return;
    end

    exp_addr = {pc[63:3], 3'b000};
    for (int i = 0; i <= ar_dly; i++) begin
      check("addr_arvalid", 64'(arvalid), 64'(1'b1));
      check("addr_rready", 64'(rready), 64'(1'b0));
      check("addr_araddr", araddr, exp_addr);
      check("addr_busy", 64'(busy), 64'(1'b1));
      check("addr_valid", 64'(inst_valid), 64'(1'b0));
      check("addr_inst_hold", 64'(inst), 64'(last_inst));
      arready   = (i == ar_dly);
      rvalid    = 1'($urandom_range(0, 1));  // must be ignored here
      rdata     = {$urandom, $urandom};
      rresp     = 2'($urandom_range(0, 3));
      fetch_req = 1'($urandom_range(0, 1));  // must be ignored while busy
      step();
    end
    arready = 1'b0;

    for (int i = 0; i <= r_dly; i++) begin
      check("data_rready", 64'(rready), 64'(1'b1));
      check("data_arvalid", 64'(arvalid), 64'(1'b0));
      check("data_araddr", araddr, exp_addr);
      check("data_busy", 64'(busy), 64'(1'b1));
      check("data_valid", 64'(inst_valid), 64'(1'b0));
      check("data_inst_hold", 64'(inst), 64'(last_inst));
      rvalid    = (i == r_dly);
      arready   = 1'($urandom_range(0, 1));  // must be ignored here
      fetch_req = 1'($urandom_range(0, 1));
      if (i == r_dly) begin
        rdata = data;
        rresp = resp;
      end else begin
        rdata = {$urandom, $urandom};
        rresp = 2'($urandom_range(0, 3));
      end
      step();
    end
    rvalid    = 1'b0;
    arready   = 1'b0;
    fetch_req = 1'b0;

    exp_err  = (resp != 2'b00);
    exp_inst = exp_err ? NOP : (pc[2] ? data[63:32] : data[31:0]);
    check("done_valid", 64'(inst_valid), 64'(1'b1));
    check("done_err", 64'(fetch_err), 64'(exp_err));
    check("done_inst", 64'(inst), 64'(exp_inst));
    check("done_busy", 64'(busy), 64'(1'b0));
    check("done_arvalid", 64'(arvalid), 64'(1'b0));
    check("done_rready", 64'(rready), 64'(1'b0));
    last_inst = exp_inst;
  endtask

  initial begin
    logic [63:0] pc;
    logic [1:0]  resp;

    n_vec     = 0;
    n_err     = 0;
    last_inst = NOP;
    rstn      = 1'b0;
    fetch_pc  = '0;
    fetch_req = 1'b0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rvalid    = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_inst", 64'(inst), 64'(NOP));
    check("rst_valid", 64'(inst_valid), 64'(1'b0));
    check("rst_err", 64'(fetch_err), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_arvalid", 64'(arvalid), 64'(1'b0));
    check("rst_rready", 64'(rready), 64'(1'b0));
    check("rst_araddr", araddr, 64'h0);
    rstn = 1'b1;

    // Minimum-latency fetches, lower and upper word
    do_fetch(64'h8000_0000, 0, 0, 64'h0010_0073_0000_0413, 2'b00);
    idle_cycle();
    do_fetch(64'h8000_0004, 0, 0, 64'h0010_0073_0000_0413, 2'b00);
    idle_cycle();
    // Stalled address and data channels
    do_fetch(64'h8000_0010, 4, 3, 64'hdead_beef_cafe_f00d, 2'b00);
    idle_cycle();
    // Error response
    do_fetch(64'h8000_0008, 1, 1, 64'h1111_2222_3333_4444, 2'b10);
    idle_cycle();
    // Misaligned pc
    do_fetch(64'h8000_0002, 0, 0, 64'h0, 2'b00);
    idle_cycle();
    // Back-to-back: second request in the valid-pulse cycle
    do_fetch(64'h8000_0020, 0, 0, 64'haaaa_bbbb_cccc_dddd, 2'b00);
    do_fetch(64'h8000_0024, 0, 0, 64'h1234_5678_9abc_def0, 2'b00);
    idle_cycle();

    // Reset during DATA, response afterwards must be ignored
    fetch_pc  = 64'h8000_0100;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    arready   = 1'b1;
    step();
    arready = 1'b0;
    check("rstx_in_data", 64'(rready), 64'(1'b1));
    #2;
    rstn = 1'b0;
    #1;
    check("rstx_busy", 64'(busy), 64'(1'b0));
    check("rstx_rready", 64'(rready), 64'(1'b0));
    check("rstx_araddr", araddr, 64'h0);
    check("rstx_inst", 64'(inst), 64'(NOP));
    check("rstx_valid", 64'(inst_valid), 64'(1'b0));
    last_inst = NOP;
    step();
    rstn   = 1'b1;
    rvalid = 1'b1;
    rdata  = 64'h5555_6666_7777_8888;
    step();
    check("rstx_late_valid", 64'(inst_valid), 64'(1'b0));
    check("rstx_late_inst", 64'(inst), 64'(NOP));
    rvalid = 1'b0;
    idle_cycle();
    do_fetch(64'h8000_0104, 0, 1, 64'h0badf00d_00000000, 2'b00);
    idle_cycle();

    // Randomized fetches
    for (int n = 0; n < 200; n++) begin
      pc = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, resp);
      if ($urandom_range(0, 1) != 0) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Parameters
REQ-001 SHALL have parameter DW, default 64: data and address width in bits.
REQ-002 SHALL have parameter IW, default 32: instruction width in bits.

Interface
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_pc  input  DW: instruction address from the pc generator.
REQ-006 SHALL have port fetch_req  input  1: request to fetch fetch_pc; sampled only in IDLE.
REQ-007 SHALL have port inst  output  IW: last fetched instruction, registered.
REQ-008 SHALL have port inst_valid  output  1: one-cycle pulse; inst updated this cycle.
REQ-009 SHALL have port fetch_err  output  1: one-cycle pulse, coincident with inst_valid, on a faulted fetch.
REQ-010 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-011 SHALL have port araddr  output  DW: bus read address, {fetch_pc[DW-1:3],3'b000}.
REQ-012 SHALL have port arvalid  output  1: address-valid.
REQ-013 SHALL have port arready  input  1: address-ready from memory.
REQ-014 SHALL have port rdata  input  DW: read data, 8-byte aligned doubleword.
REQ-015 SHALL have port rresp  input  2: read response; 2'b00 OK, any other value is an error.
REQ-016 SHALL have port rvalid  input  1: read-data valid.
REQ-017 SHALL have port rready  output  1: read-data ready.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-019 IDLE & fetch_req & fetch_pc[1:0]==0 SHALL move to ADDR, capture fetch_pc[2] as the word select, and register araddr.
REQ-020 IDLE & fetch_req & fetch_pc[1:0]!=0 (misaligned) SHALL stay in IDLE, issue no bus transaction, and on the next cycle set inst=32'h00000013 (nop) with inst_valid=1 and fetch_err=1.
REQ-021 In ADDR: arvalid=1; araddr SHALL be held stable until arvalid&arready at a clock edge, then move to DATA.
REQ-022 In DATA: rready=1; on rvalid&rready at a clock edge SHALL move to IDLE.
REQ-023 On DATA completion, inst SHALL load rdata[63:32] if the word select is 1, else rdata[31:0]; inst_valid SHALL pulse for exactly the following cycle.
REQ-024 On DATA completion with rresp!=0, inst SHALL load 32'h00000013 instead, and fetch_err SHALL pulse with inst_valid.
REQ-025 Minimum latency SHALL be: fetch_req sampled at edge E0 -> arvalid high after E0 -> (arready=1) edge E1 -> (rvalid=1) edge E2 -> inst_valid high after E2.
REQ-026 fetch_req in ADDR or DATA SHALL be ignored (not queued); the requester holds it until busy=0.
REQ-027 fetch_req SHALL be accepted in the same cycle inst_valid is high (back-to-back fetches).
REQ-028 Outside a valid pulse, inst SHALL hold its value; inst_valid and fetch_err SHALL be 0.
REQ-029 arvalid and rready SHALL never be high in the same cycle.
REQ-030 rvalid while not in DATA SHALL be ignored; arready while not in ADDR SHALL be ignored.

Reset
REQ-031 rstn=0 SHALL immediately force state=IDLE, inst=32'h00000013, inst_valid=0, fetch_err=0, arvalid=0, rready=0, araddr=0, busy=0.
REQ-032 Reset asserted mid-transaction (ADDR or DATA) SHALL abandon it with no inst_valid pulse; a response arriving later is ignored.
REQ-033 After rstn deasserts, the first fetch_req SHALL be sampled on the first rising edge.

Verification
REQ-034 fetch_pc=0x80000000, arready=1, rvalid=1, rdata=0x00100073_00000413 -> araddr=0x80000000; inst=0x00000413, inst_valid 1 cycle, total 3 edges.
REQ-035 fetch_pc=0x80000004, same rdata -> inst=0x00100073, fetch_err=0.
REQ-036 arready low 4 cycles, then rvalid delayed 3 cycles -> araddr stable throughout; exactly one inst_valid pulse; busy high throughout.
REQ-037 rresp=2'b10 -> inst=0x00000013, inst_valid=1 and fetch_err=1 in the same cycle.
REQ-038 fetch_pc=0x80000002 -> no arvalid; next cycle inst=0x00000013, fetch_err=1.
REQ-039 rstn pulsed low during DATA, then rvalid=1 -> no inst_valid; outputs at reset values; next fetch completes normally.
